// File: rtl/pwm_capture_pkg.sv
// Purpose: shared CSR map, bit positions and address decode for the PWM capture block.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package pwm_capture_pkg;

  // CSR byte addresses; only wb_adr_i[7:0] is decoded.
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_DIV    = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_PERIOD = 8'h0C;
  localparam logic [7:0] ADDR_HIGH   = 8'h10;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bit positions.
  localparam int STAT_VALID_BIT = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_ARMED_BIT = 2;

  typedef enum logic [2:0] {
    CSR_CTRL,
    CSR_DIV,
    CSR_STATUS,
    CSR_PERIOD,
    CSR_HIGH,
    CSR_NONE
  } csr_sel_e;

  function automatic csr_sel_e decode_csr(input logic [7:0] adr);
    csr_sel_e sel;
    case (adr)
      ADDR_CTRL:   sel = CSR_CTRL;
      ADDR_DIV:    sel = CSR_DIV;
      ADDR_STATUS: sel = CSR_STATUS;
      ADDR_PERIOD: sel = CSR_PERIOD;
      ADDR_HIGH:   sel = CSR_HIGH;
      default:     sel = CSR_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// Purpose: bring the asynchronous PWM pin into clk domain and detect its edges.
// Latency: rise/fall assert combinationally in the cycle after the 2nd sampling edge.
// Backpressure: none; free-running pipeline.
//
// Ports:
//   clk, resetb    : clock and async active-low reset
//   pwm_in         : raw asynchronous pin
//   rise, fall     : single-cycle edge pulses derived from the synchronized level
module pwm_capture_sync (
  input  logic clk,
  input  logic resetb,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = pwm_in;
    s2_d = s1_q;
    // s3 is the history flop: the previous synchronized level.
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture_wb.sv
// Purpose: Wishbone slave that measures PWM period and high time in prescaled ticks.
// Latency: results land 3 clk edges after the pin change is first sampled; bus acks 1 cycle after request.
// Backpressure: single-cycle ack, at most one ack every other cycle under continuous strobe.
//
// Ports:
//   clk, resetb          : clock and async active-low reset
//   wb_*                 : Wishbone slave (32-bit data, adr[7:0] decoded, any sel bit = full word)
//   pwm_in               : asynchronous PWM pin
//   irq                  : registered level interrupt, IRQ_EN & (VALID | OVF)
module pwm_capture_wb
  import pwm_capture_pkg::*;
#(
  parameter int DIV_BITS = 16,
  parameter int CNT_BITS = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic [31:0] wb_adr_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  input  logic        pwm_in,
  output logic        irq
);

  // Edge detection on the synchronized pin.
  logic rise;
  logic fall;

  pwm_capture_sync u_sync (
    .clk    (clk),
    .resetb (resetb),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Bus state.
  logic                ack_q,      ack_d;
  logic [31:0]         dat_o_q,    dat_o_d;

  // CSRs.
  logic                en_q,       en_d;
  logic                irq_en_q,   irq_en_d;
  logic [DIV_BITS-1:0] div_q,      div_d;
  logic                valid_q,    valid_d;
  logic                ovf_q,      ovf_d;
  logic [CNT_BITS-1:0] period_q,   period_d;
  logic [CNT_BITS-1:0] high_q,     high_d;

  // Measurement engine.
  logic [DIV_BITS-1:0] div_cnt_q,  div_cnt_d;
  logic [CNT_BITS-1:0] cnt_q,      cnt_d;
  logic [CNT_BITS-1:0] high_cap_q, high_cap_d;
  logic                armed_q,    armed_d;
  logic                irq_q,      irq_d;

  // Combinational helpers.
  logic        req;
  logic        wr;
  logic        rd;
  csr_sel_e    csr;
  logic [31:0] rd_data;
  logic        tick;
  logic        set_valid;
  logic        set_ovf;
  logic        clr_valid;
  logic        clr_ovf;

  // Upper address bits and unused data bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[31:8], wb_dat_i};

  // Bus decode and read mux.
  always_comb begin
    req     = wb_stb_i & wb_cyc_i & ~ack_q;
    wr      = req & wb_we_i & (|wb_sel_i);
    rd      = req & ~wb_we_i;
    csr     = decode_csr(wb_adr_i[7:0]);
    rd_data = '0;
    case (csr)
      CSR_CTRL: begin
        rd_data[CTRL_EN_BIT]     = en_q;
        rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      CSR_DIV:    rd_data[DIV_BITS-1:0] = div_q;
      CSR_STATUS: begin
        rd_data[STAT_VALID_BIT] = valid_q;
        rd_data[STAT_OVF_BIT]   = ovf_q;
        rd_data[STAT_ARMED_BIT] = armed_q;
      end
      CSR_PERIOD: rd_data[CNT_BITS-1:0] = period_q;
      CSR_HIGH:   rd_data[CNT_BITS-1:0] = high_q;
      default:    rd_data = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    ack_d      = req;
    dat_o_d    = dat_o_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    div_d      = div_q;
    period_d   = period_q;
    high_d     = high_q;
    div_cnt_d  = div_cnt_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    armed_d    = armed_q;
    set_valid  = 1'b0;
    set_ovf    = 1'b0;
    clr_valid  = 1'b0;
    clr_ovf    = 1'b0;

    // Read data is captured on the same edge that raises ack.
    if (rd) begin
      dat_o_d = rd_data;
    end

    if (wr) begin
      case (csr)
        CSR_CTRL: begin
          en_d     = wb_dat_i[CTRL_EN_BIT];
          irq_en_d = wb_dat_i[CTRL_IRQ_EN_BIT];
        end
        CSR_DIV: div_d = wb_dat_i[DIV_BITS-1:0];
        CSR_STATUS: begin
          clr_valid = wb_dat_i[STAT_VALID_BIT];
          clr_ovf   = wb_dat_i[STAT_OVF_BIT];
        end
        default: ;
      endcase
    end

    // Prescaler. Using >= rather than == means a DIV reduced below the
    // running count ticks immediately instead of wrapping the whole range.
    tick = en_q && (div_cnt_q >= div_q);
    if (!en_q || rise || tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_BITS'(1);
    end

    // Measurement counter. Rise has priority over any coincident tick, and
    // restarting the prescaler on rise keeps results phase-aligned to the
    // input so exact multiples of DIV+1 divide out cleanly.
    if (!en_q) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (rise) begin
      if (armed_q) begin
        period_d  = cnt_q;
        high_d    = high_cap_q;
        set_valid = 1'b1;
      end
      armed_d = 1'b1;
      cnt_d   = CNT_BITS'(1);
    end else begin
      if (fall && armed_q) begin
        high_cap_d = cnt_q;
      end
      if (tick && armed_q) begin
        if (&cnt_q) begin
          // Stuck-at input: give up on this measurement and wait for a rise.
          set_ovf = 1'b1;
          armed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
    end

    // A hardware set in the same cycle as a W1C leaves the flag set.
    valid_d = (valid_q & ~clr_valid) | set_valid;
    ovf_d   = (ovf_q & ~clr_ovf) | set_ovf;

    irq_d = irq_en_q & (valid_q | ovf_q);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      div_q      <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      period_q   <= '0;
      high_q     <= '0;
      div_cnt_q  <= '0;
      cnt_q      <= '0;
      high_cap_q <= '0;
      armed_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      div_q      <= div_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      period_q   <= period_d;
      high_q     <= high_d;
      div_cnt_q  <= div_cnt_d;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
      armed_q    <= armed_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_o_q;
  assign irq      = irq_q;

endmodule
